// File: rtl/blockram_port_initiator.sv
// blockram_port_initiator: turns a valid/ready request stream into accesses on one
// dual_port_blockram port and returns read data through a small in-order response FIFO.
// Read credits (in-flight reads plus buffered responses) are capped at RESP_DEPTH so the
// response FIFO can never overflow.

`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module blockram_port_initiator #(
    parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int unsigned NUM_SET                   = 64,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int unsigned WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int unsigned RESP_DEPTH                = 2
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,

    input  logic                                 req_valid_in,
    output logic                                 req_ready_out,
    input  logic [WRITE_MASK_LEN-1:0]            req_write_mask_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     req_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] req_write_entry_in,

    output logic                                 ram_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_access_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_write_entry_out,

    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_read_entry_in,
    input  logic                                 ram_read_valid_in,

    output logic                                 resp_valid_out,
    input  logic                                 resp_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp_entry_out,

    output logic                                 protocol_error_out
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    // Registered state
    logic                                 r_req_ready;
    logic [CNT_W-1:0]                     r_in_flight;
    logic [CNT_W-1:0]                     r_count;
    logic [PTR_W-1:0]                     r_wr_ptr;
    logic [PTR_W-1:0]                     r_rd_ptr;
    logic                                 r_resp_valid;
    logic                                 r_protocol_error;
    logic                                 r_ram_access_en;
    logic [WRITE_MASK_LEN-1:0]            r_ram_write_en;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     r_ram_addr;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_ram_entry;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] r_buf [0:RESP_DEPTH-1];

    // Handshake decode
    logic w_req_fire;
    logic w_issue_read;
    logic w_ret_ok;
    logic w_ret_bad;
    logic w_pop;

    // Next-state values
    logic [CNT_W-1:0] w_in_flight_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [OCC_W-1:0] w_occ_nxt;

    assign w_req_fire   = req_valid_in & r_req_ready;
    assign w_issue_read = w_req_fire & ~(|req_write_mask_in);
    assign w_ret_ok     = ram_read_valid_in & (r_in_flight != '0);
    assign w_ret_bad    = ram_read_valid_in & (r_in_flight == '0);
    assign w_pop        = r_resp_valid & resp_ready_in;

    // Credit counters and FIFO pointer updates
    always_comb begin
        w_in_flight_nxt = r_in_flight;
        w_count_nxt     = r_count;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;

        if (w_issue_read && !w_ret_ok) begin
            w_in_flight_nxt = r_in_flight + CNT_W'(1);
        end else if (!w_issue_read && w_ret_ok) begin
            w_in_flight_nxt = r_in_flight - CNT_W'(1);
        end

        if (w_ret_ok && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_ret_ok && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end

        if (w_ret_ok) begin
            w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
        end

        w_occ_nxt = OCC_W'(w_in_flight_nxt) + OCC_W'(w_count_nxt);
    end

    // Control state, credit-based ready and sticky protocol error
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_req_ready      <= 1'b0;
            r_in_flight      <= '0;
            r_count          <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_resp_valid     <= 1'b0;
            r_protocol_error <= 1'b0;
        end else begin
            r_req_ready      <= (w_occ_nxt < OCC_W'(RESP_DEPTH));
            r_in_flight      <= w_in_flight_nxt;
            r_count          <= w_count_nxt;
            r_wr_ptr         <= w_wr_ptr_nxt;
            r_rd_ptr         <= w_rd_ptr_nxt;
            r_resp_valid     <= (w_count_nxt != '0);
            r_protocol_error <= r_protocol_error | w_ret_bad;
        end
    end

    // RAM port drive: one-cycle access pulse per accepted request, zeros when idle
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_ram_access_en <= 1'b0;
            r_ram_write_en  <= '0;
            r_ram_addr      <= '0;
            r_ram_entry     <= '0;
        end else if (w_req_fire) begin
            r_ram_access_en <= 1'b1;
            r_ram_write_en  <= req_write_mask_in;
            r_ram_addr      <= req_set_addr_in;
            r_ram_entry     <= req_write_entry_in;
        end else begin
            r_ram_access_en <= 1'b0;
            r_ram_write_en  <= '0;
            r_ram_addr      <= '0;
            r_ram_entry     <= '0;
        end
    end

    // Response FIFO storage; unexpected returns are never written
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < int'(RESP_DEPTH); i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_ret_ok) begin
            r_buf[r_wr_ptr] <= ram_read_entry_in;
        end
    end

    assign req_ready_out           = r_req_ready;
    assign ram_access_en_out       = r_ram_access_en;
    assign ram_write_en_out        = r_ram_write_en;
    assign ram_access_set_addr_out = r_ram_addr;
    assign ram_write_entry_out     = r_ram_entry;
    assign resp_valid_out          = r_resp_valid;
    assign resp_entry_out          = r_buf[r_rd_ptr];
    assign protocol_error_out      = r_protocol_error;

endmodule

// File: tb/tb_blockram_port_initiator.sv
// Directed bench for blockram_port_initiator: instance A uses RESP_DEPTH=2, instance B
// uses RESP_DEPTH=4; each has its own behavioural block RAM behind the port.

module tb_blockram_port_initiator;

    localparam int unsigned EW = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned MW = 8;
    localparam logic [EW-1:0] PAT_A  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [EW-1:0] PAT_LO = 64'h0000_0000_FFFF_FFFF;
    localparam logic [EW-1:0] PAT_B  = 64'hC0DE_0000_0000_0000;

    logic clk_in = 1'b0;
    logic reset_in;

    logic          a_req_valid, a_req_ready;
    logic [MW-1:0] a_req_mask;
    logic [AW-1:0] a_req_addr;
    logic [EW-1:0] a_req_entry;
    logic          a_ram_en;
    logic [MW-1:0] a_ram_we;
    logic [AW-1:0] a_ram_addr;
    logic [EW-1:0] a_ram_wentry, a_ram_rentry;
    logic          a_ram_rv_model, a_force_rv, a_ram_rv;
    logic          a_resp_valid, a_resp_ready, a_perr;
    logic [EW-1:0] a_resp_entry;
    logic [EW-1:0] a_mem [0:63];

    logic          b_req_valid, b_req_ready;
    logic [MW-1:0] b_req_mask;
    logic [AW-1:0] b_req_addr;
    logic [EW-1:0] b_req_entry;
    logic          b_ram_en;
    logic [MW-1:0] b_ram_we;
    logic [AW-1:0] b_ram_addr;
    logic [EW-1:0] b_ram_wentry, b_ram_rentry;
    logic          b_ram_rv;
    logic          b_resp_valid, b_resp_ready, b_perr;
    logic [EW-1:0] b_resp_entry;
    logic [EW-1:0] b_mem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    assign a_ram_rv = a_ram_rv_model | a_force_rv;

    blockram_port_initiator #(.RESP_DEPTH(2)) u_dut_a (
        .clk_in(clk_in), .reset_in(reset_in),
        .req_valid_in(a_req_valid), .req_ready_out(a_req_ready),
        .req_write_mask_in(a_req_mask), .req_set_addr_in(a_req_addr),
        .req_write_entry_in(a_req_entry),
        .ram_access_en_out(a_ram_en), .ram_write_en_out(a_ram_we),
        .ram_access_set_addr_out(a_ram_addr), .ram_write_entry_out(a_ram_wentry),
        .ram_read_entry_in(a_ram_rentry), .ram_read_valid_in(a_ram_rv),
        .resp_valid_out(a_resp_valid), .resp_ready_in(a_resp_ready),
        .resp_entry_out(a_resp_entry), .protocol_error_out(a_perr)
    );

    blockram_port_initiator #(.RESP_DEPTH(4)) u_dut_b (
        .clk_in(clk_in), .reset_in(reset_in),
        .req_valid_in(b_req_valid), .req_ready_out(b_req_ready),
        .req_write_mask_in(b_req_mask), .req_set_addr_in(b_req_addr),
        .req_write_entry_in(b_req_entry),
        .ram_access_en_out(b_ram_en), .ram_write_en_out(b_ram_we),
        .ram_access_set_addr_out(b_ram_addr), .ram_write_entry_out(b_ram_wentry),
        .ram_read_entry_in(b_ram_rentry), .ram_read_valid_in(b_ram_rv),
        .resp_valid_out(b_resp_valid), .resp_ready_in(b_resp_ready),
        .resp_entry_out(b_resp_entry), .protocol_error_out(b_perr)
    );

    // Block RAM model A: byte-masked write, one-cycle registered read return
    always @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            a_ram_rv_model <= 1'b0;
            a_ram_rentry   <= '0;
            for (int i = 0; i < 64; i++) a_mem[i] <= '0;
        end else begin
            a_ram_rv_model <= 1'b0;
            if (a_ram_en) begin
                if (a_ram_we == '0) begin
                    a_ram_rentry   <= a_mem[a_ram_addr];
                    a_ram_rv_model <= 1'b1;
                end else begin
                    for (int k = 0; k < int'(MW); k++)
                        if (a_ram_we[k]) a_mem[a_ram_addr][k*8 +: 8] <= a_ram_wentry[k*8 +: 8];
                end
            end
        end
    end

    // Block RAM model B
    always @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            b_ram_rv     <= 1'b0;
            b_ram_rentry <= '0;
            for (int i = 0; i < 64; i++) b_mem[i] <= '0;
        end else begin
            b_ram_rv <= 1'b0;
            if (b_ram_en) begin
                if (b_ram_we == '0) begin
                    b_ram_rentry <= b_mem[b_ram_addr];
                    b_ram_rv     <= 1'b1;
                end else begin
                    for (int k = 0; k < int'(MW); k++)
                        if (b_ram_we[k]) b_mem[b_ram_addr][k*8 +: 8] <= b_ram_wentry[k*8 +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic a_issue(input logic [MW-1:0] m, input logic [AW-1:0] ad, input logic [EW-1:0] d);
        a_req_valid = 1'b1; a_req_mask = m; a_req_addr = ad; a_req_entry = d;
        tick();
        a_req_valid = 1'b0; a_req_mask = '0; a_req_addr = '0; a_req_entry = '0;
    endtask

    task automatic a_wait_resp(output int cyc);
        cyc = 0;
        while (a_resp_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        a_req_valid = 1'b0; a_req_mask = '0; a_req_addr = '0; a_req_entry = '0;
        a_resp_ready = 1'b0; a_force_rv = 1'b0;
        b_req_valid = 1'b0; b_req_mask = '0; b_req_addr = '0; b_req_entry = '0;
        b_resp_ready = 1'b0;
        tick();
        tick();
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", a_req_ready); end
        checks++; if (a_ram_en !== 1'b0 || a_ram_we !== '0) begin failures++; $display("FAIL rst_ram_en got=%b/%h exp=0/00", a_ram_en, a_ram_we); end
        checks++; if (a_ram_addr !== '0 || a_ram_wentry !== '0) begin failures++; $display("FAIL rst_ram_addr got=%h/%h exp=0/0", a_ram_addr, a_ram_wentry); end
        checks++; if (a_resp_valid !== 1'b0 || a_resp_entry !== '0) begin failures++; $display("FAIL rst_resp got=%b/%h exp=0/0", a_resp_valid, a_resp_entry); end
        checks++; if (a_perr !== 1'b0) begin failures++; $display("FAIL rst_perr got=%b exp=0", a_perr); end
        reset_in = 1'b0;
        #1;
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_before_edge got=%b exp=0", a_req_ready); end
        tick();
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after_edge got=%b exp=1", a_req_ready); end
        checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%b exp=1", b_req_ready); end
    endtask

    task automatic test_write_read();
        a_resp_ready = 1'b0;
        a_issue(8'hFF, 6'd63, PAT_A);
        checks++; if (a_ram_en !== 1'b1 || a_ram_we !== 8'hFF) begin failures++; $display("FAIL wr_ram_en got=%b/%h exp=1/ff", a_ram_en, a_ram_we); end
        checks++; if (a_ram_addr !== 6'd63 || a_ram_wentry !== PAT_A) begin failures++; $display("FAIL wr_ram_addr got=%h/%h exp=3f/%h", a_ram_addr, a_ram_wentry, PAT_A); end
        tick();
        checks++; if (a_ram_en !== 1'b0 || a_ram_we !== '0 || a_ram_addr !== '0 || a_ram_wentry !== '0)
            begin failures++; $display("FAIL idle_ram got=%b/%h/%h/%h exp=0/0/0/0", a_ram_en, a_ram_we, a_ram_addr, a_ram_wentry); end
        a_issue(8'h00, 6'd63, '0);
        checks++; if (a_ram_en !== 1'b1 || a_ram_we !== 8'h00 || a_ram_addr !== 6'd63)
            begin failures++; $display("FAIL rd_ram got=%b/%h/%h exp=1/00/3f", a_ram_en, a_ram_we, a_ram_addr); end
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_no_early_resp got=%b exp=0", a_resp_valid); end
        tick();
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_lat1 got=%b exp=0", a_resp_valid); end
        tick();
        checks++; if (a_resp_valid !== 1'b1 || a_resp_entry !== PAT_A) begin failures++; $display("FAIL rd_lat2 got=%b/%h exp=1/%h", a_resp_valid, a_resp_entry, PAT_A); end
        tick();
        checks++; if (a_resp_valid !== 1'b1 || a_resp_entry !== PAT_A) begin failures++; $display("FAIL rd_hold got=%b/%h exp=1/%h", a_resp_valid, a_resp_entry, PAT_A); end
        a_resp_ready = 1'b1;
        tick();
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_popped got=%b exp=0", a_resp_valid); end
    endtask

    task automatic test_partial_write();
        int cyc;
        a_resp_ready = 1'b1;
        a_issue(8'h0F, 6'd1, {EW{1'b1}});
        a_issue(8'h00, 6'd1, '0);
        a_wait_resp(cyc);
        checks++; if (cyc != 2) begin failures++; $display("FAIL pw_latency got=%0d exp=2", cyc); end
        checks++; if (a_resp_entry !== PAT_LO) begin failures++; $display("FAIL pw_data got=%h exp=%h", a_resp_entry, PAT_LO); end
        tick();
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL pw_single_resp got=%b exp=0", a_resp_valid); end
    endtask

    task automatic test_backpressure();
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_mask = '0; a_req_addr = 6'd63;
        tick();
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", a_req_ready); end
        a_req_addr = 6'd1;
        tick();
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", a_req_ready); end
        a_req_addr = 6'd63;
        repeat (4) tick();
        checks++; if (a_req_ready !== 1'b0 || a_ram_en !== 1'b0) begin failures++; $display("FAIL bp_stalled got=%b/%b exp=0/0", a_req_ready, a_ram_en); end
        checks++; if (a_resp_valid !== 1'b1 || a_resp_entry !== PAT_A) begin failures++; $display("FAIL bp_head0 got=%b/%h exp=1/%h", a_resp_valid, a_resp_entry, PAT_A); end
        a_resp_ready = 1'b1;
        tick();
        checks++; if (a_resp_valid !== 1'b1 || a_resp_entry !== PAT_LO) begin failures++; $display("FAIL bp_head1 got=%b/%h exp=1/%h", a_resp_valid, a_resp_entry, PAT_LO); end
        checks++; if (a_req_ready !== 1'b1 || a_ram_en !== 1'b0) begin failures++; $display("FAIL bp_reopen got=%b/%b exp=1/0", a_req_ready, a_ram_en); end
        tick();
        a_req_valid = 1'b0; a_req_addr = '0;
        checks++; if (a_resp_valid !== 1'b0 || a_ram_en !== 1'b1 || a_ram_addr !== 6'd63)
            begin failures++; $display("FAIL bp_third_issue got=%b/%b/%h exp=0/1/3f", a_resp_valid, a_ram_en, a_ram_addr); end
        tick();
        tick();
        checks++; if (a_resp_valid !== 1'b1 || a_resp_entry !== PAT_A) begin failures++; $display("FAIL bp_third_resp got=%b/%h exp=1/%h", a_resp_valid, a_resp_entry, PAT_A); end
        tick();
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin failures++; $display("FAIL bp_drained got=%b/%b exp=0/1", a_resp_valid, a_req_ready); end
    endtask

    task automatic test_protocol_error();
        a_force_rv = 1'b1;
        tick();
        a_force_rv = 1'b0;
        checks++; if (a_perr !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", a_perr); end
        checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL perr_no_resp got=%b exp=0", a_resp_valid); end
        repeat (3) tick();
        checks++; if (a_perr !== 1'b1 || a_resp_valid !== 1'b0) begin failures++; $display("FAIL perr_sticky got=%b/%b exp=1/0", a_perr, a_resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        b_resp_ready = 1'b1;
        b_req_valid  = 1'b1;
        b_req_mask   = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            b_req_addr  = AW'(i);
            b_req_entry = PAT_B | EW'(i);
            tick();
        end
        b_req_mask = '0; b_req_entry = '0;
        checks++; if (b_resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_write_no_resp got=%b exp=0", b_resp_valid); end
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                b_req_valid = 1'b1;
                b_req_addr  = AW'(c);
                checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, b_req_ready); end
            end else begin
                b_req_valid = 1'b0;
                b_req_addr  = '0;
            end
            tick();
            exp_v = (c >= 2 && c <= 9);
            checks++; if (b_resp_valid !== exp_v) begin failures++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, b_resp_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (b_resp_entry !== (PAT_B | EW'(c - 2))) begin
                    failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, b_resp_entry, PAT_B | EW'(c - 2));
                end
            end
        end
        checks++; if (b_perr !== 1'b0) begin failures++; $display("FAIL b2b_perr got=%b exp=0", b_perr); end
    endtask

    task automatic test_reset_inflight();
        a_resp_ready = 1'b1;
        checks++; if (a_perr !== 1'b1) begin failures++; $display("FAIL rsi_perr_before got=%b exp=1", a_perr); end
        a_issue(8'h00, 6'd63, '0);
        a_issue(8'h00, 6'd1, '0);
        reset_in = 1'b1;
        #1;
        checks++; if (a_ram_en !== 1'b0 || a_ram_addr !== '0) begin failures++; $display("FAIL rsi_ram got=%b/%h exp=0/0", a_ram_en, a_ram_addr); end
        checks++; if (a_req_ready !== 1'b0 || a_perr !== 1'b0) begin failures++; $display("FAIL rsi_ctl got=%b/%b exp=0/0", a_req_ready, a_perr); end
        checks++; if (a_resp_valid !== 1'b0 || a_resp_entry !== '0) begin failures++; $display("FAIL rsi_resp got=%b/%h exp=0/0", a_resp_valid, a_resp_entry); end
        tick();
        tick();
        reset_in = 1'b0;
        tick();
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rsi_ready got=%b exp=1", a_req_ready); end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rsi_stale c=%0d got=%b exp=0", c, a_resp_valid); end
        end
        checks++; if (a_perr !== 1'b0) begin failures++; $display("FAIL rsi_perr_after got=%b exp=0", a_perr); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_protocol_error();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
